// File: rtl/gray_multidigit_display.sv
// Switch code reader: gray/binary decode, sequential double-dabble to BCD,
// and a multiplexed seven-segment scan with optional leading-zero blanking.

module gray_multidigit_display_add3 (
    input  logic [3:0] nib,
    output logic [3:0] adj
);
    assign adj = (nib >= 4'd5) ? nib + 4'd3 : nib;
endmodule

module gray_multidigit_display #(
    parameter int WIDTH           = 8,
    parameter int DIGITS          = 3,
    parameter int INPUT_REFRESH   = 2700000,
    parameter int DISPLAY_REFRESH = 27000
) (
    input  logic              clk_pi,
    input  logic              rst_pi,
    input  logic [WIDTH-1:0]  codigo_gray_pi,
    input  logic              modo_pi,
    input  logic              blank_pi,
    output logic [DIGITS-1:0] anodo_po,
    output logic [6:0]        catodo_po,
    output logic [WIDTH-1:0]  codigo_bin_led_po,
    output logic              valido_po
);
    localparam int SMP_W = $clog2(INPUT_REFRESH);
    localparam int REF_W = $clog2(DISPLAY_REFRESH);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int SH_W  = DIGITS * 4 + WIDTH;

    localparam logic [SMP_W-1:0] SMP_LAST  = SMP_W'(INPUT_REFRESH - 1);
    localparam logic [REF_W-1:0] REF_LAST  = REF_W'(DISPLAY_REFRESH - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    logic [WIDTH-1:0]           code_s1, code_s2, gray_bin, dec;
    logic                       modo_s1, modo_s2;
    logic [SMP_W-1:0]           smp_cnt;
    logic                       tick, tick_d, first_pend, req;
    logic [WIDTH-1:0]           codigo_bin, last_bin, src, shreg;
    logic [DIGITS-1:0][3:0]     scratch, adj, bcd;
    logic [SH_W-1:0]            sh_next;
    logic [CNT_W-1:0]           iter;
    state_t                     state, state_nxt;
    logic [REF_W-1:0]           ref_cnt;
    logic [IDX_W-1:0]           idx;
    logic [DIGITS-1:0]          zero_hi;
    logic [3:0]                 sel_nib;
    logic                       sel_blank;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    always_ff @(posedge clk_pi or posedge rst_pi) begin
        if (rst_pi) begin
            code_s1 <= '0;
            code_s2 <= '0;
            modo_s1 <= 1'b0;
            modo_s2 <= 1'b0;
        end else begin
            code_s1 <= codigo_gray_pi;
            code_s2 <= code_s1;
            modo_s1 <= modo_pi;
            modo_s2 <= modo_s1;
        end
    end

    // Each binary bit is the parity of the gray bits at and above it.
    for (genvar i = 0; i < WIDTH; i++) begin : g_gray
        assign gray_bin[i] = ^code_s2[WIDTH-1:i];
    end
    assign dec  = modo_s2 ? code_s2 : gray_bin;
    assign tick = (smp_cnt == SMP_LAST);
    assign req  = tick_d && (first_pend || (codigo_bin != last_bin));

    always_ff @(posedge clk_pi or posedge rst_pi) begin
        if (rst_pi) begin
            smp_cnt    <= '0;
            codigo_bin <= '0;
            tick_d     <= 1'b0;
            first_pend <= 1'b1;
        end else begin
            smp_cnt <= tick ? '0 : smp_cnt + 1'b1;
            tick_d  <= tick;
            if (tick)   codigo_bin <= dec;
            if (tick_d) first_pend <= 1'b0;
        end
    end

    for (genvar k = 0; k < DIGITS; k++) begin : g_dd
        gray_multidigit_display_add3 u_add3 (.nib(scratch[k]), .adj(adj[k]));
    end
    assign sh_next = {adj, shreg} << 1;

    always_ff @(posedge clk_pi or posedge rst_pi) begin
        if (rst_pi) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req) state_nxt = LOAD;
            LOAD:    state_nxt = SHIFT;
            SHIFT:   if (iter == ITER_LAST) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        valido_po = (state == DONE);
    end

    // The final shift commits straight into bcd so it is valid during DONE.
    always_ff @(posedge clk_pi or posedge rst_pi) begin
        if (rst_pi) begin
            shreg    <= '0;
            scratch  <= '0;
            iter     <= '0;
            src      <= '0;
            bcd      <= '0;
            last_bin <= '0;
        end else begin
            case (state)
                LOAD: begin
                    shreg   <= codigo_bin;
                    src     <= codigo_bin;
                    scratch <= '0;
                    iter    <= '0;
                end
                SHIFT: begin
                    shreg   <= sh_next[WIDTH-1:0];
                    scratch <= sh_next[SH_W-1:WIDTH];
                    iter    <= iter + 1'b1;
                    if (iter == ITER_LAST) begin
                        bcd      <= sh_next[SH_W-1:WIDTH];
                        last_bin <= src;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_pi or posedge rst_pi) begin
        if (rst_pi) begin
            ref_cnt <= '0;
            idx     <= '0;
        end else if (ref_cnt == REF_LAST) begin
            ref_cnt <= '0;
            idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            ref_cnt <= ref_cnt + 1'b1;
        end
    end

    for (genvar k = 0; k < DIGITS; k++) begin : g_zero
        assign zero_hi[k] = ~|bcd[DIGITS-1:k];
    end

    always_comb begin
        sel_nib   = '0;
        sel_blank = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                sel_nib   = bcd[k];
                sel_blank = blank_pi && (k != 0) && zero_hi[k];
            end
        end
    end

    always_ff @(posedge clk_pi or posedge rst_pi) begin
        if (rst_pi) begin
            anodo_po  <= ~DIGITS'(1);
            catodo_po <= 7'b1000000;
        end else begin
            anodo_po  <= ~(DIGITS'(1) << idx);
            catodo_po <= sel_blank ? 7'b1111111 : seg7(sel_nib);
        end
    end

    assign codigo_bin_led_po = ~codigo_bin;
endmodule

// File: tb/tb_gray_multidigit_display.sv
// Scoreboard bench: expected LED/display values are queued when a code is
// driven and popped when the design signals a committed conversion.

module tb_gray_multidigit_display;
    localparam int W = 8, D = 3, IR = 16, DR = 4;

    logic         clk = 1'b0, rst = 1'b1, modo = 1'b0, blank = 1'b0;
    logic [W-1:0] code = '0;
    logic [D-1:0] anodo;
    logic [6:0]   catodo;
    logic [W-1:0] led;
    logic         valido;
    int           checks = 0, errors = 0;

    typedef struct {
        logic [W-1:0]       led;
        logic [D-1:0][6:0]  seg;
    } exp_t;
    exp_t sb[$];

    gray_multidigit_display #(.WIDTH(W), .DIGITS(D), .INPUT_REFRESH(IR),
                              .DISPLAY_REFRESH(DR)) dut (
        .clk_pi(clk), .rst_pi(rst), .codigo_gray_pi(code), .modo_pi(modo),
        .blank_pi(blank), .anodo_po(anodo), .catodo_po(catodo),
        .codigo_bin_led_po(led), .valido_po(valido));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [W-1:0] model_bin(input logic [W-1:0] c, input logic m);
        logic [W-1:0] b;
        b = '0;
        if (m) return c;
        for (int s = 0; s < W; s++) b ^= c >> s;
        return b;
    endfunction

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;  1: return 7'b1111001;
            2: return 7'b0100100;  3: return 7'b0110000;
            4: return 7'b0011001;  5: return 7'b0010010;
            6: return 7'b0000010;  7: return 7'b1111000;
            8: return 7'b0000000;  9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] exp_digit(input int v, input logic bl, input int k);
        int p;
        p = 1;
        for (int j = 0; j < k; j++) p *= 10;
        if (bl && k > 0 && v < p) return 7'b1111111;
        return seg_of((v / p) % 10);
    endfunction

    task automatic drive(input logic [W-1:0] c, input logic m, input bit push);
        exp_t e;
        code = c;
        modo = m;
        if (push) begin
            e.led = ~model_bin(c, m);
            for (int k = 0; k < D; k++) e.seg[k] = exp_digit(int'(model_bin(c, m)), blank, k);
            sb.push_back(e);
        end
    endtask

    task automatic wait_valido(output bit seen, output int delay);
        logic [W-1:0] prev;
        int t_led;
        prev = led; t_led = -1; seen = 1'b0; delay = -1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (led !== prev && t_led < 0) t_led = c;
            if (valido === 1'b1) begin
                seen = 1'b1;
                delay = (t_led >= 0) ? c - t_led : -1;
                break;
            end
        end
    endtask

    task automatic capture(input int ncyc, output logic [D-1:0][6:0] seg,
                           output int vcnt, output int bad_an);
        seg = 'x; vcnt = 0; bad_an = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (valido === 1'b1) vcnt++;
            case (anodo)
                3'b110:  seg[0] = catodo;
                3'b101:  seg[1] = catodo;
                3'b011:  seg[2] = catodo;
                default: bad_an++;
            endcase
        end
    endtask

    task automatic test_reset;
        bit seen; int dly, v, b; exp_t e; logic [D-1:0][6:0] seg;
        repeat (3) @(negedge clk);
        checks++; if (anodo !== 3'b110) begin errors++; $display("FAIL reset_anodo: got %b expected 110", anodo); end
        checks++; if (catodo !== 7'b1000000) begin errors++; $display("FAIL reset_catodo: got %b expected 1000000", catodo); end
        checks++; if (led !== 8'hFF) begin errors++; $display("FAIL reset_led: got %h expected ff", led); end
        checks++; if (valido !== 1'b0) begin errors++; $display("FAIL reset_valido: got %b expected 0", valido); end
        drive(8'h00, 1'b0, 1'b1);
        rst = 1'b0;
        wait_valido(seen, dly);
        checks++; if (!seen) begin errors++; $display("FAIL first_tick_valido: got none expected pulse"); end
        if (sb.size() == 0) begin errors++; $display("FAIL reset_scoreboard: got empty queue expected entry"); return; end
        e = sb.pop_front();
        checks++; if (led !== e.led) begin errors++; $display("FAIL first_tick_led: got %h expected %h", led, e.led); end
        repeat (2) @(negedge clk);
        capture(14, seg, v, b);
        for (int k = 0; k < D; k++) begin
            checks++; if (seg[k] !== e.seg[k]) begin errors++; $display("FAIL reset_digit%0d: got %b expected %b", k, seg[k], e.seg[k]); end
        end
        checks++; if (v != 0 || b != 0) begin errors++; $display("FAIL reset_scan: got valido=%0d bad_anodo=%0d expected 0,0", v, b); end
    endtask

    // Drives one code, waits for its conversion, and checks LEDs, latency and all digits.
    task automatic test_convert(input string name, input logic [W-1:0] c, input logic m);
        bit seen; int dly, v, b; exp_t e; logic [D-1:0][6:0] seg;
        drive(c, m, 1'b1);
        wait_valido(seen, dly);
        checks++; if (!seen) begin errors++; $display("FAIL %s_valido: got none expected pulse", name); end
        if (sb.size() == 0) begin errors++; $display("FAIL %s_scoreboard: got empty queue expected entry", name); return; end
        e = sb.pop_front();
        checks++; if (led !== e.led) begin errors++; $display("FAIL %s_led: got %h expected %h", name, led, e.led); end
        checks++; if (dly != W + 2) begin errors++; $display("FAIL %s_latency: got %0d expected %0d", name, dly, W + 2); end
        @(negedge clk);
        checks++; if (valido !== 1'b0) begin errors++; $display("FAIL %s_pulse_width: got %b expected 0", name, valido); end
        @(negedge clk);
        capture(14, seg, v, b);
        for (int k = 0; k < D; k++) begin
            checks++; if (seg[k] !== e.seg[k]) begin errors++; $display("FAIL %s_digit%0d: got %b expected %b", name, k, seg[k], e.seg[k]); end
        end
        checks++; if (v != 0 || b != 0) begin errors++; $display("FAIL %s_scan: got valido=%0d bad_anodo=%0d expected 0,0", name, v, b); end
    endtask

    task automatic test_blanking;
        int v, b; logic [D-1:0][6:0] seg; logic [6:0] ex;
        blank = 1'b1;
        test_convert("blank7", 8'b00000100, 1'b0);
        blank = 1'b0;
        repeat (2) @(negedge clk);
        capture(14, seg, v, b);
        for (int k = 0; k < D; k++) begin
            ex = exp_digit(7, 1'b0, k);
            checks++; if (seg[k] !== ex) begin errors++; $display("FAIL noblank7_digit%0d: got %b expected %b", k, seg[k], ex); end
        end
        blank = 1'b1;
        test_convert("blank0", 8'h00, 1'b0);
    endtask

    task automatic test_no_change;
        int v;
        logic [W-1:0] l0;
        v = 0; l0 = led;
        for (int c = 0; c < 5 * IR + 8; c++) begin
            @(negedge clk);
            if (valido === 1'b1) v++;
        end
        checks++; if (v != 0) begin errors++; $display("FAIL no_change_valido: got %0d pulses expected 0", v); end
        checks++; if (led !== l0) begin errors++; $display("FAIL no_change_led: got %h expected %h", led, l0); end
    endtask

    task automatic test_scan;
        logic [D-1:0] exs [4] = '{3'b110, 3'b101, 3'b011, 3'b110};
        logic [D-1:0] prev;
        int run;
        bit found;
        found = 1'b0;
        for (int c = 0; c < 30; c++) begin
            prev = anodo;
            @(negedge clk);
            if (prev !== 3'b110 && anodo === 3'b110) begin found = 1'b1; break; end
        end
        checks++; if (!found) begin errors++; $display("FAIL scan_sync: got no 110 entry expected one"); return; end
        for (int s = 0; s < 4; s++) begin
            checks++; if (anodo !== exs[s]) begin errors++; $display("FAIL scan_anodo%0d: got %b expected %b", s, anodo, exs[s]); end
            run = 0;
            while (anodo === exs[s] && run < 20) begin run++; @(negedge clk); end
            checks++; if (run != DR) begin errors++; $display("FAIL scan_hold%0d: got %0d expected %0d", s, run, DR); end
        end
    endtask

    task automatic test_reset_abort;
        int v, b, vr; logic [D-1:0][6:0] seg; logic [W-1:0] prev; bit chg;
        blank = 1'b0;
        test_convert("pre_abort", 8'd123, 1'b1);
        prev = led; chg = 1'b0; vr = 0;
        drive(8'd200, 1'b1, 1'b0);
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (led !== prev) begin chg = 1'b1; break; end
        end
        checks++; if (!chg) begin errors++; $display("FAIL abort_led_change: got none expected change"); end
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (anodo !== 3'b110) begin errors++; $display("FAIL abort_anodo: got %b expected 110", anodo); end
        checks++; if (catodo !== 7'b1000000) begin errors++; $display("FAIL abort_catodo: got %b expected 1000000", catodo); end
        checks++; if (led !== 8'hFF) begin errors++; $display("FAIL abort_led: got %h expected ff", led); end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (valido === 1'b1) vr++;
        end
        rst = 1'b0;
        capture(13, seg, v, b);
        checks++; if (v + vr != 0) begin errors++; $display("FAIL abort_valido: got %0d pulses expected 0", v + vr); end
        for (int k = 0; k < D; k++) begin
            checks++; if (seg[k] !== 7'b1000000) begin errors++; $display("FAIL abort_digit%0d: got %b expected 1000000", k, seg[k]); end
        end
    endtask

    initial begin
        test_reset();
        test_convert("gray", 8'b11010010, 1'b0);
        test_convert("binary", 8'hFF, 1'b1);
        test_blanking();
        test_no_change();
        test_scan();
        test_reset_abort();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
